// File: rtl/data_memory_arbiter.sv
// Two-master round-robin arbiter for a single synchronous data memory.
// Read data returns to its owner READ_LATENCY cycles after the grant, through a tag pipeline.
module data_memory_arbiter #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [3:0]  MemWriteEnable,
    output logic [31:0] addr_out,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);

    // Set when master 1 received the most recent grant; reset value lets master 0 win first.
    logic                    r_last_m1;
    logic [READ_LATENCY-1:0] r_tag_valid;
    logic [READ_LATENCY-1:0] r_tag_owner;

    logic w_gnt0;
    logic w_gnt1;
    logic w_any_gnt;
    logic w_read;
    logic w_ret_valid;
    logic w_ret_owner;
    logic w_unused_addr_lsbs;

    assign w_gnt0    = m0_req & (~m1_req | r_last_m1);
    assign w_gnt1    = m1_req & (~m0_req | ~r_last_m1);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    assign w_read = (w_gnt0 & (m0_we == 4'h0)) | (w_gnt1 & (m1_we == 4'h0));

    always_comb begin
        MemWriteEnable = 4'h0;
        addr_out       = 32'h0;
        data_out       = 32'h0;
        if (w_gnt0) begin
            MemWriteEnable = m0_we;
            addr_out       = {m0_addr[31:2], 2'b00};
            data_out       = m0_wdata;
        end else if (w_gnt1) begin
            MemWriteEnable = m1_we;
            addr_out       = {m1_addr[31:2], 2'b00};
            data_out       = m1_wdata;
        end
    end

    assign w_unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_m1 <= 1'b1;
        end else if (w_any_gnt) begin
            r_last_m1 <= w_gnt1;
        end
    end

    // Every cycle shifts; only read grants enter as valid, so writes never produce a return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_valid <= '0;
            r_tag_owner <= '0;
        end else begin
            r_tag_valid[0] <= w_read;
            r_tag_owner[0] <= w_gnt1;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_owner[i] <= r_tag_owner[i-1];
            end
        end
    end

    assign w_ret_valid = r_tag_valid[READ_LATENCY-1];
    assign w_ret_owner = r_tag_owner[READ_LATENCY-1];

    assign m0_rvalid = w_ret_valid & ~w_ret_owner;
    assign m1_rvalid = w_ret_valid & w_ret_owner;
    assign m0_rdata  = m0_rvalid ? data_in : 32'h0;
    assign m1_rdata  = m1_rvalid ? data_in : 32'h0;

endmodule
